// File: rtl/dram_bank_timing_tracker_pkg.sv
// Shared types and default DDR4 timing values for the bank timing tracker.
package dram_bank_timing_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PRECHG = 2'd2
    } bank_state_t;

    typedef enum logic [2:0] {
        ACT  = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        PRE  = 3'd3,
        PREA = 3'd4
    } trk_op_t;

    // Default speed-bin timings, in CLK cycles
    localparam int DEF_T_RCD   = 12;
    localparam int DEF_T_RAS   = 19;
    localparam int DEF_T_RP    = 10;
    localparam int DEF_T_RRD_S = 4;
    localparam int DEF_T_RRD_L = 4;
    localparam int DEF_T_CCD_S = 4;
    localparam int DEF_T_CCD_L = 5;
    localparam int DEF_T_FAW   = 25;
    localparam int DEF_CNT_W   = 8;

    // A counter loaded with T-1 at issue reaches 0 exactly T cycles later; T=0 means no wait
    function automatic int unsigned cnt_load(input int unsigned t);
        return (t == 0) ? 0 : t - 1;
    endfunction

endpackage

// File: rtl/dram_bank_timing_tracker_if.sv
// Issued-command and candidate-query bus between scheduler/command FSM and the tracker.
interface dram_bank_timing_tracker_if #(
    parameter int BG_BITS  = 2,
    parameter int BA_BITS  = 2,
    parameter int ROW_BITS = 18
);
    import dram_bank_timing_tracker_pkg::*;

    logic                cmd_valid;
    trk_op_t             cmd_op;
    logic [BG_BITS-1:0]  cmd_bg;
    logic [BA_BITS-1:0]  cmd_ba;
    logic [ROW_BITS-1:0] cmd_row;

    trk_op_t             q_op;
    logic [BG_BITS-1:0]  q_bg;
    logic [BA_BITS-1:0]  q_ba;
    logic [ROW_BITS-1:0] q_row;
    logic                q_ok;
    logic                q_hit;

    modport master (
        output cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row,
        output q_op, q_bg, q_ba, q_row,
        input  q_ok, q_hit
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row,
        input  q_op, q_bg, q_ba, q_row,
        output q_ok, q_hit
    );

endinterface

// File: rtl/dram_bank_timing_tracker_bank_fsm.sv
// One DRAM bank: IDLE/ACTIVE/PRECHG state, open row and tRCD/tRAS/tRP counters.
module dram_bank_timing_tracker_bank_fsm
    import dram_bank_timing_tracker_pkg::*;
#(
    parameter int ROW_BITS = 18,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RAS    = DEF_T_RAS,
    parameter int T_RP     = DEF_T_RP
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                do_act,
    input  logic                do_pre,
    input  logic [ROW_BITS-1:0] act_row,
    output bank_state_t         state,
    output logic [ROW_BITS-1:0] row,
    output logic                rcd_ok,
    output logic                ras_ok
);
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(cnt_load(T_RCD));
    localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(cnt_load(T_RAS));
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(cnt_load(T_RP));

    bank_state_t      state_d;
    logic [CNT_W-1:0] rcd_cnt, ras_cnt, rp_cnt;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

    // Next state: ACT (legal or not) opens the bank, PRE only closes an open bank,
    // PRECHG leaves on the edge where tRP hits 0 so the bank reads IDLE when ACT becomes legal
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (do_act) state_d = ACTIVE;
            ACTIVE:  if (!do_act && do_pre) state_d = (LD_RP == '0) ? IDLE : PRECHG;
            PRECHG:  if (do_act) state_d = ACTIVE;
                     else if (rp_cnt <= CNT_W'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_d;
    end

    // Open-row latch and per-bank timing counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            row     <= '0;
            rcd_cnt <= '0;
            ras_cnt <= '0;
            rp_cnt  <= '0;
        end else begin
            if (do_act) begin
                row     <= act_row;
                rcd_cnt <= LD_RCD;
                ras_cnt <= LD_RAS;
            end else begin
                rcd_cnt <= dec_sat(rcd_cnt);
                ras_cnt <= dec_sat(ras_cnt);
            end
            if (do_pre && !do_act && state == ACTIVE) rp_cnt <= LD_RP;
            else                                      rp_cnt <= dec_sat(rp_cnt);
        end
    end

    assign rcd_ok = (rcd_cnt == '0);
    assign ras_ok = (ras_cnt == '0);

endmodule

// File: rtl/dram_bank_timing_tracker.sv
// Per-bank state/timing tracker: bank FSM array plus RRD/CCD/FAW windows,
// a combinational legality query and a registered illegal-issue flag.
module dram_bank_timing_tracker
    import dram_bank_timing_tracker_pkg::*;
#(
    parameter int BG_BITS  = 2,
    parameter int BA_BITS  = 2,
    parameter int ROW_BITS = 18,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RAS    = DEF_T_RAS,
    parameter int T_RP     = DEF_T_RP,
    parameter int T_RRD_S  = DEF_T_RRD_S,
    parameter int T_RRD_L  = DEF_T_RRD_L,
    parameter int T_CCD_S  = DEF_T_CCD_S,
    parameter int T_CCD_L  = DEF_T_CCD_L,
    parameter int T_FAW    = DEF_T_FAW,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    dram_bank_timing_tracker_if.slave             bus,
    output logic [(2**(BG_BITS+BA_BITS))-1:0]     bank_open,
    output logic                                  all_idle,
    output logic                                  violation
);
    localparam int IDX_W = BG_BITS + BA_BITS;
    localparam int NB    = 2**IDX_W;
    localparam logic [CNT_W-1:0] LD_RRD_S = CNT_W'(cnt_load(T_RRD_S));
    localparam logic [CNT_W-1:0] LD_RRD_L = CNT_W'(cnt_load(T_RRD_L));
    localparam logic [CNT_W-1:0] LD_CCD_S = CNT_W'(cnt_load(T_CCD_S));
    localparam logic [CNT_W-1:0] LD_CCD_L = CNT_W'(cnt_load(T_CCD_L));
    localparam logic [CNT_W-1:0] LD_FAW   = CNT_W'(cnt_load(T_FAW));

    bank_state_t         st   [NB];
    logic [ROW_BITS-1:0] rows [NB];
    logic [NB-1:0]       rcd_ok, ras_ok, is_idle, do_act, do_pre;
    logic [IDX_W-1:0]    cmd_idx, q_idx;
    logic [CNT_W-1:0]    rrd_s, rrd_l, ccd_s, ccd_l;
    logic [BG_BITS-1:0]  last_act_bg, last_rw_bg;
    logic [CNT_W-1:0]    faw [4];
    logic [1:0]          faw_ptr;
    logic                faw_free, prea_ok, cmd_legal, cmd_is_act, cmd_is_rw;
    logic                q_rrd0, q_ccd0, c_rrd0, c_ccd0;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

    function automatic logic legal_f(input trk_op_t op, input bank_state_t bs,
                                     input logic row_eq, input logic rcd0, input logic ras0,
                                     input logic rrd0, input logic ccd0,
                                     input logic faw0, input logic prea0);
        logic ok;
        ok = 1'b0;
        case (op)
            ACT:     ok = (bs == IDLE) && rrd0 && faw0;
            RD, WR:  ok = (bs == ACTIVE) && row_eq && rcd0 && ccd0;
            PRE:     ok = (bs == IDLE) || ((bs == ACTIVE) && ras0);
            PREA:    ok = prea0;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign cmd_idx    = {bus.cmd_bg, bus.cmd_ba};
    assign q_idx      = {bus.q_bg, bus.q_ba};
    assign cmd_is_act = bus.cmd_valid && (bus.cmd_op == ACT);
    assign cmd_is_rw  = bus.cmd_valid && (bus.cmd_op == RD || bus.cmd_op == WR);

    for (genvar g = 0; g < NB; g++) begin : g_bank
        assign do_act[g] = cmd_is_act && (cmd_idx == IDX_W'(g));
        assign do_pre[g] = bus.cmd_valid &&
                           ((bus.cmd_op == PRE && cmd_idx == IDX_W'(g)) || bus.cmd_op == PREA);

        dram_bank_timing_tracker_bank_fsm #(
            .ROW_BITS(ROW_BITS), .CNT_W(CNT_W),
            .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RP(T_RP)
        ) u_bank (
            .CLK(CLK), .nRST(nRST),
            .do_act(do_act[g]), .do_pre(do_pre[g]), .act_row(bus.cmd_row),
            .state(st[g]), .row(rows[g]), .rcd_ok(rcd_ok[g]), .ras_ok(ras_ok[g])
        );

        assign bank_open[g] = (st[g] == ACTIVE);
        assign is_idle[g]   = (st[g] == IDLE);
    end

    // A bank only reaches IDLE once its tRP has run out, so all-IDLE covers both conditions
    assign all_idle = &is_idle;
    assign prea_ok  = &(ras_ok | ~bank_open);
    assign faw_free = (faw[0] == '0) || (faw[1] == '0) || (faw[2] == '0) || (faw[3] == '0);

    // The long (same-group) window only matters when the target group matches the last one
    assign q_rrd0 = (rrd_s == '0) && ((bus.q_bg != last_act_bg) || (rrd_l == '0));
    assign q_ccd0 = (ccd_s == '0) && ((bus.q_bg != last_rw_bg)  || (ccd_l == '0));
    assign c_rrd0 = (rrd_s == '0) && ((bus.cmd_bg != last_act_bg) || (rrd_l == '0));
    assign c_ccd0 = (ccd_s == '0) && ((bus.cmd_bg != last_rw_bg)  || (ccd_l == '0));

    assign bus.q_ok  = legal_f(bus.q_op, st[q_idx], rows[q_idx] == bus.q_row,
                               rcd_ok[q_idx], ras_ok[q_idx], q_rrd0, q_ccd0, faw_free, prea_ok);
    assign bus.q_hit = bank_open[q_idx] && (rows[q_idx] == bus.q_row);
    assign cmd_legal = legal_f(bus.cmd_op, st[cmd_idx], rows[cmd_idx] == bus.cmd_row,
                               rcd_ok[cmd_idx], ras_ok[cmd_idx], c_rrd0, c_ccd0, faw_free, prea_ok);

    // ACT-to-ACT and column-to-column spacing, short and long variants run side by side
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rrd_s       <= '0;
            rrd_l       <= '0;
            ccd_s       <= '0;
            ccd_l       <= '0;
            last_act_bg <= '0;
            last_rw_bg  <= '0;
        end else begin
            if (cmd_is_act) begin
                rrd_s       <= LD_RRD_S;
                rrd_l       <= LD_RRD_L;
                last_act_bg <= bus.cmd_bg;
            end else begin
                rrd_s <= dec_sat(rrd_s);
                rrd_l <= dec_sat(rrd_l);
            end
            if (cmd_is_rw) begin
                ccd_s      <= LD_CCD_S;
                ccd_l      <= LD_CCD_L;
                last_rw_bg <= bus.cmd_bg;
            end else begin
                ccd_s <= dec_sat(ccd_s);
                ccd_l <= dec_sat(ccd_l);
            end
        end
    end

    // Four-activate window: ring of four slots, each ACT reloads the oldest one
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 4; i++) faw[i] <= '0;
            faw_ptr <= '0;
        end else begin
            for (int i = 0; i < 4; i++) faw[i] <= dec_sat(faw[i]);
            if (cmd_is_act) begin
                faw[faw_ptr] <= LD_FAW;
                faw_ptr      <= faw_ptr + 2'd1;
            end
        end
    end

    // One-cycle flag for an issued command that broke a rule
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) violation <= 1'b0;
        else       violation <= bus.cmd_valid && !cmd_legal;
    end

endmodule

// File: tb/tb_dram_bank_timing_tracker.sv
// Directed bench for dram_bank_timing_tracker with hand-computed cycle expectations.
module tb_dram_bank_timing_tracker;
    import dram_bank_timing_tracker_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic [15:0] bank_open;
    logic        all_idle, violation;
    int          n_cmp = 0;
    int          n_err = 0;

    dram_bank_timing_tracker_if #(.BG_BITS(2), .BA_BITS(2), .ROW_BITS(18)) bus ();

    dram_bank_timing_tracker dut (
        .CLK(CLK), .nRST(nRST), .bus(bus),
        .bank_open(bank_open), .all_idle(all_idle), .violation(violation)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input trk_op_t op, input int bg, input int ba, input int row);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_bg    = 2'(bg);
        bus.cmd_ba    = 2'(ba);
        bus.cmd_row   = 18'(row);
    endtask

    task automatic ask(input trk_op_t op, input int bg, input int ba, input int row);
        bus.q_op  = op;
        bus.q_bg  = 2'(bg);
        bus.q_ba  = 2'(ba);
        bus.q_row = 18'(row);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        drive(ACT, 0, 0, 0);
        bus.cmd_valid = 1'b0;
        ask(ACT, 0, 0, 0);

        // Reset state and first ACT -> RD tRCD window
        do_reset();
        ask(ACT, 0, 0, 0); #1 chk("rst_qok_act", bus.q_ok, 1);
        ask(PRE, 0, 0, 0); #1 chk("rst_qok_pre", bus.q_ok, 1);
        ask(RD,  0, 0, 0); #1 chk("rst_qok_rd",  bus.q_ok, 0);
        chk("rst_qhit", bus.q_hit, 0);
        ask(WR,  0, 0, 0); #1 chk("rst_qok_wr",  bus.q_ok, 0);
        chk("rst_bank_open", bank_open, 0);
        chk("rst_all_idle", all_idle, 1);
        chk("rst_violation", violation, 0);
        step();
        for (int c = 0; c <= 12; c++) begin
            if (c == 0) drive(ACT, 0, 0, 5);
            ask(RD, 0, 0, 5);
            #2;
            if (c == 0)  chk("rcd_c0_ok", bus.q_ok, 0);
            if (c == 1)  chk("rcd_c1_hit", bus.q_hit, 1);
            if (c == 1)  chk("rcd_c1_open", bank_open, 16'h0001);
            if (c == 1)  chk("rcd_c1_idle", all_idle, 0);
            if (c == 11) chk("rcd_c11_ok", bus.q_ok, 0);
            if (c == 12) chk("rcd_c12_ok", bus.q_ok, 1);
            if (c == 12) begin
                ask(RD, 0, 0, 6); #1 chk("rcd_c12_miss", bus.q_hit, 0);
            end
            step();
        end

        // tRAS: PRE at 18 is illegal, PRE at 19 is legal, then tRP before the next ACT
        for (int p = 0; p < 2; p++) begin
            do_reset();
            for (int c = 0; c <= 29; c++) begin
                if (c == 0) drive(ACT, 0, 0, 5);
                if (c == 18 + p) drive(PRE, 0, 0, 0);
                if (c <= 18 + p) ask(PRE, 0, 0, 0);
                else             ask(ACT, 0, 0, 9);
                #2;
                if (c == 18 + p) chk("ras_pre_ok", bus.q_ok, p);
                if (c == 19 + p) chk("ras_viol", violation, (p == 0) ? 1 : 0);
                if (c == 19 + p) chk("ras_closed", bank_open, 0);
                if (c == 20 + p) chk("ras_viol_end", violation, 0);
                if (p == 1 && c == 28) chk("rp_c28_ok", bus.q_ok, 0);
                if (p == 1 && c == 28) chk("rp_c28_idle", all_idle, 0);
                if (p == 1 && c == 29) chk("rp_c29_ok", bus.q_ok, 1);
                if (p == 1 && c == 29) chk("rp_c29_idle", all_idle, 1);
                step();
            end
        end

        // tFAW: four ACTs into BG0 block a BG1 ACT until cycle 25
        do_reset();
        for (int c = 0; c <= 25; c++) begin
            if (c % 4 == 0 && c <= 12) drive(ACT, 0, c / 4, 1);
            ask(ACT, 1, 0, 1);
            #2;
            if (c == 2)  chk("rrd_c2_ok", bus.q_ok, 0);
            if (c == 4)  chk("rrd_c4_ok", bus.q_ok, 1);
            if (c == 13) chk("faw_viol", violation, 0);
            if (c == 13) chk("faw_open", bank_open, 16'h000f);
            if (c == 16) chk("faw_c16_ok", bus.q_ok, 0);
            if (c == 24) chk("faw_c24_ok", bus.q_ok, 0);
            if (c == 25) chk("faw_c25_ok", bus.q_ok, 1);
            step();
        end

        // tCCD_L/S: RD to BG0 at 20, same group at 25, other group at 24
        for (int p = 0; p < 2; p++) begin
            do_reset();
            for (int c = 0; c <= 25; c++) begin
                if (c == 0)  drive(ACT, 0, 0, 7);
                if (c == 4)  drive(ACT, 1, 0, 7);
                if (c == 20) drive(RD, 0, 0, 7);
                if (c == 23)      ask(RD, 1, 0, 7);
                else if (c == 24) ask(RD, p, 0, 7);
                else              ask(RD, 0, 0, 7);
                #2;
                if (c == 21) chk("ccd_viol", violation, 0);
                if (c == 23) chk("ccd_c23_bg1", bus.q_ok, 0);
                if (c == 24) chk((p == 0) ? "ccd_c24_bg0" : "ccd_c24_bg1", bus.q_ok, p);
                if (c == 25) chk("ccd_c25_bg0", bus.q_ok, 1);
                step();
            end
        end

        // PREA with three open banks, then asynchronous reset in the middle of tRP
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            if (c == 0)  drive(ACT, 0, 0, 3);
            if (c == 4)  drive(ACT, 1, 0, 3);
            if (c == 8)  drive(ACT, 2, 0, 3);
            if (c == 27) drive(PREA, 0, 0, 0);
            if (c == 28) drive(ACT, 3, 0, 3);
            if (c <= 27) ask(PREA, 0, 0, 0);
            else         ask(ACT, 0, 0, 3);
            #2;
            if (c == 26) chk("prea_c26_ok", bus.q_ok, 0);
            if (c == 27) chk("prea_c27_ok", bus.q_ok, 1);
            if (c == 27) chk("prea_open", bank_open, 16'h0111);
            if (c == 28) chk("prea_viol", violation, 0);
            if (c == 28) chk("prea_closed", bank_open, 0);
            if (c == 28) chk("act_prechg_ok", bus.q_ok, 0);
            if (c == 29) chk("act_bg3_open", bank_open, 16'h1000);
            if (c == 29) chk("prea_busy_idle", all_idle, 0);
            if (c == 30) begin
                nRST = 1'b0;
                #1;
                chk("arst_open", bank_open, 0);
                chk("arst_idle", all_idle, 1);
                chk("arst_act_ok", bus.q_ok, 1);
                chk("arst_viol", violation, 0);
            end else begin
                step();
            end
        end
        do_reset();
        ask(ACT, 0, 0, 3); #1 chk("post_rst_act_ok", bus.q_ok, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
